// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the data-memory access path:
//                region codes, region field position in the byte address,
//                and the access-controller FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Region code as seen by the write-enable demux and the read-data mux.
    typedef enum logic [1:0] {
        REGION_RAM      = 2'b00,
        REGION_BANK2    = 2'b01,
        REGION_BANK3    = 2'b10,
        REGION_UNMAPPED = 2'b11
    } regionT;

    // Position of the region field inside a byte address.
    localparam int c_REGION_MSB = 13;
    localparam int c_REGION_LSB = 12;

    // Width of the read-latency down-counter (latency range 1..4).
    localparam int c_LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WRITE     = 2'b01,
        ST_READ_WAIT = 2'b10,
        ST_RESP      = 2'b11
    } stateT;

    function automatic logic isUnmapped(input regionT region);
        return region == REGION_UNMAPPED;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : region_decode
//  Description : Combinational address-to-region mapping. Shared between the
//                data-access controller and the instruction-fetch side so
//                both agree on the memory map.
//  Ports       : addr   - byte address (ADDR_W bits, must be > 13)
//                region - 2-bit region code (RAM / BANK2 / BANK3 / UNMAPPED)
//  Revision    : 1.0  initial release
// ============================================================================
module region_decode
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output regionT            region
);

    // Only the region field matters; the remaining address bits are
    // deliberately ignored by the map.
    logic w_unusedAddr;

    assign region       = regionT'(addr[c_REGION_MSB:c_REGION_LSB]);
    assign w_unusedAddr = &addr;

endmodule : region_decode
`default_nettype wire

// File: rtl/mem_region_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_region_ctrl
//  Description : Registered data-memory access controller. Accepts one
//                load/store at a time over valid/ready, decodes the region,
//                drives registered address/data/strobes to the banks, waits
//                the bank read latency, muxes read data and returns a single
//                cycle response. Unmapped accesses are flagged and counted.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                req_*               - request handshake and payload
//                resp_*              - one-cycle response (data, error)
//                MemorySelector      - registered region code to demux
//                MemWrite / MemRead  - bank strobes
//                MemAddr / MemWData  - registered address and store data
//                RData_1..RData_3    - read data from RAM, bank 2, bank 3
//                err_count           - saturating unmapped-access counter
//  Revision    : 1.0  initial release
// ============================================================================
module mem_region_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1      // legal range 1..4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,

    output logic [1:0]        MemorySelector,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,

    input  logic [DATA_W-1:0] RData_1,
    input  logic [DATA_W-1:0] RData_2,
    input  logic [DATA_W-1:0] RData_3,

    output logic [7:0]        err_count
);

    localparam logic [c_LAT_CNT_W-1:0] c_LAT_INIT = c_LAT_CNT_W'(READ_LAT);

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    stateT                  r_state;
    logic [c_LAT_CNT_W-1:0] r_latCnt;
    regionT                 r_sel;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_memWrite;
    logic                   r_memRead;
    logic                   r_respValid;
    logic                   r_respErr;
    logic [DATA_W-1:0]      r_respRdata;
    logic [7:0]             r_errCount;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    regionT                 w_region;
    logic                   w_accept;
    logic                   w_reqUnmapped;
    logic [c_LAT_CNT_W-1:0] w_latCntNext;
    logic [DATA_W-1:0]      w_bankData;

    region_decode #(
        .ADDR_W (ADDR_W)
    ) u_regionDecode (
        .addr   (req_addr),
        .region (w_region)
    );

    // Ready is a pure decode of the registered state, so it is glitch-free
    // and falls in the cycle right after an acceptance.
    assign req_ready     = (r_state == ST_IDLE);
    assign w_accept      = req_valid && req_ready;
    assign w_reqUnmapped = isUnmapped(w_region);
    assign w_latCntNext  = r_latCnt - 1'b1;

    // Read-data mux keyed on the registered selector, which stays stable
    // for the whole read wait. Unmapped space reads as zero.
    always_comb begin
        w_bankData = '0;
        case (r_sel)
            REGION_RAM:      w_bankData = RData_1;
            REGION_BANK2:    w_bankData = RData_2;
            REGION_BANK3:    w_bankData = RData_3;
            REGION_UNMAPPED: w_bankData = '0;
            default:         w_bankData = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_latCnt    <= '0;
            r_sel       <= REGION_RAM;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_memWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respRdata <= '0;
            r_errCount  <= '0;
        end else begin
            // Strobes and the response are single-cycle pulses; the data
            // output is zero outside the response cycle of a load.
            r_memWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respRdata <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= w_region;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;

                        if (w_reqUnmapped && (r_errCount != 8'hFF)) begin
                            r_errCount <= r_errCount + 8'd1;
                        end

                        if (req_write) begin
                            // Store completes in the next cycle, so its
                            // response is raised together with the strobe.
                            r_memWrite  <= !w_reqUnmapped;
                            r_respValid <= 1'b1;
                            r_respErr   <= w_reqUnmapped;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_memRead <= 1'b1;
                            r_latCnt  <= c_LAT_INIT;
                            r_state   <= ST_READ_WAIT;
                        end
                    end
                end

                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end

                ST_READ_WAIT: begin
                    // The counter holds READ_LAT on the first wait cycle, so
                    // reaching zero marks the end of cycle T+READ_LAT, when
                    // the bank data is valid.
                    r_latCnt <= w_latCntNext;
                    if (w_latCntNext == '0) begin
                        r_respRdata <= w_bankData;
                        r_respValid <= 1'b1;
                        r_respErr   <= isUnmapped(r_sel);
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign MemorySelector = r_sel;
    assign MemWrite       = r_memWrite;
    assign MemRead        = r_memRead;
    assign MemAddr        = r_addr;
    assign MemWData       = r_wdata;
    assign resp_valid     = r_respValid;
    assign resp_err       = r_respErr;
    assign resp_rdata     = r_respRdata;
    assign err_count      = r_errCount;

endmodule : mem_region_ctrl
`default_nettype wire

// File: doc/mem_region_ctrl.md
# mem_region_ctrl

Registered data-memory access controller between the processor's load/store port and the memory write-enable demux. It accepts one request at a time over a valid/ready handshake and decodes the address into the 2-bit `MemorySelector` region code. It drives registered address, data and write enable toward the memory banks. For reads it waits a configurable bank latency, muxes the selected bank's read data and returns a one-cycle response; accesses to unmapped space are flagged and counted.

## Interface
- `ADDR_W`, 32: request/memory address width.
- `DATA_W`, 32: data width.
- `READ_LAT`, 1: bank read latency in cycles, legal range 1–4.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address; bits [13:12] select the region.
- `req_wdata` in DATA_W: store data.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out DATA_W: load data, 0 for stores and unmapped loads.
- `resp_err` out 1: unmapped access; qualified by `resp_valid`.
- `MemorySelector` out 2: 00 main RAM, 01 bank 2, 10 bank 3, 11 unmapped.
- `MemWrite` out 1: write strobe, consumed by the write-enable demux.
- `MemRead` out 1: read strobe to all banks.
- `MemAddr` out ADDR_W: registered address.
- `MemWData` out DATA_W: registered store data.
- `RData_1`, `RData_2`, `RData_3` in DATA_W: read data from main RAM, bank 2 and bank 3.
- `err_count` out 8: saturating count of unmapped accesses.

## Operation
- FSM states: IDLE, WRITE, READ_WAIT, RESP.
- Handshake: acceptance when `req_valid && req_ready`; request fields are sampled only then.
- IDLE:
  - Accepted store → WRITE.
  - Accepted load → READ_WAIT, latency counter loaded with `READ_LAT`.
- WRITE (one cycle):
  - `MemWrite` = 1 unless region is 11; `resp_valid` = 1.
  - Next state IDLE.
- READ_WAIT:
  - `MemRead` = 1 on the first cycle only.
  - Counter decrements each cycle; at 0, data from the bank given by the registered selector is captured into `resp_rdata` (forced to 0 for region 11).
  - Next state RESP.
- RESP (one cycle): `resp_valid` = 1, then IDLE.
- `MemorySelector`, `MemAddr` and `MemWData` are held stable from the cycle after acceptance until the next acceptance.
- Region 11:
  - `MemWrite` is never asserted; the load takes the normal latency and returns 0.
  - `resp_err` = 1.
  - `err_count` increments at acceptance and saturates at 255.
- `req_valid` while not ready is ignored; no request is queued.
- Reset in any state:
  - Next state IDLE; any in-flight response is dropped.
  - All outputs 0 except `req_ready`, which is 1; `err_count` clears.

## Timing
- Store accepted at cycle T:
  - `MemWrite`, `MemAddr`, `MemWData`, `MemorySelector` and `resp_valid` are valid in T+1.
  - `req_ready` is high again in T+2.
  - Maximum store throughput is one every 2 cycles.
- Load accepted at cycle T:
  - `MemRead` and address are valid in T+1.
  - Bank data is sampled at the end of cycle T+`READ_LAT`.
  - `resp_valid` and `resp_rdata` are valid in T+`READ_LAT`+1.
  - `req_ready` is high in T+`READ_LAT`+2.
- `resp_valid` is exactly one cycle per accepted request, with no back-pressure on responses.
- Reset values: `req_ready` = 1; everything else is 0, including `MemorySelector` = 00.

## Structure
- Shared package `mem_pkg` holds:
  - the region enum (RAM=00, BANK2=01, BANK3=10, UNMAPPED=11);
  - the region field bit positions [13:12];
  - the FSM state typedef.
- One natural sub-module, `region_decode`: a combinational mapping from address to region code, reused by the instruction-fetch side.
- Read-data mux and FSM stay in the top module.

## Test plan
- Reset with `req_valid`=1 held high → no acceptance during reset; after release `req_ready`=1, `MemorySelector`=00, `err_count`=0.
- Store to `addr`=0x1004, `wdata`=0xDEADBEEF at T:
  - In T+1: `MemWrite`=1, `MemorySelector`=01, `MemAddr`=0x1004, `resp_valid`=1.
  - `req_ready` is low in T+1 and high in T+2.
- Load from 0x2010 with `READ_LAT`=3 and `RData_3`=0x12345678 → `resp_valid` only in T+4 with `resp_rdata`=0x12345678; `RData_1`/`RData_2` changes have no effect.
- Store to 0x3000 → `MemWrite` stays 0, `MemorySelector`=11, `resp_err`=1, `err_count`=1. 256 further unmapped accesses → `err_count`=255.
- Reset asserted in READ_WAIT → no `resp_valid` afterwards; the next load returns correct data at the normal latency.
- Back-to-back: load 0x0000 then store 0x1000 with `req_valid` held high → second acceptance exactly at T+`READ_LAT`+2; one response per request, in order.
